scm_gen: RTL and testbench



---
 rtl/scm_gen_pkg.sv | 29 ++
 rtl/scm_gen_init.sv | 54 +++++
 rtl/scm_gen.sv | 85 ++++++++
 tb/tb_scm_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/scm_gen_pkg.sv
// Shared types, default geometry and the byte-merge helper for the scm_gen storage macro.
package scm_gen_pkg;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 64;

  // The merge helper works on the widest supported row; callers cast in and out.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_row,
    input logic [MAX_DATA_WIDTH-1:0] din,
    input logic [MAX_BE_WIDTH-1:0]   be
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_row;
    for (int i = 0; i < MAX_BE_WIDTH; i++) begin
      if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/scm_gen_init.sv
// Post-reset clear sweep: walks every row once, then hands the array to the user ports.
module scm_gen_init
  import scm_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_init_we,
  output logic [ADDR_WIDTH-1:0] o_init_addr,
  output logic                  o_init_busy
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_init_we   = 1'b0;
    o_init_busy = 1'b0;
    case (r_state)
      S_INIT: begin
        o_init_we   = 1'b1;
        o_init_busy = 1'b1;
        w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
        if (r_cnt == {ADDR_WIDTH{1'b1}}) w_state_nxt = S_READY;
      end
      S_READY: begin
        w_state_nxt = S_READY;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign o_init_addr = r_cnt;

endmodule

// File: rtl/scm_gen.sv
// One-write/one-read standard-cell memory with byte-masked writes, registered read and clear sweep.
// Define SCM_BYPASS_EN to forward same-row same-edge write data to the read port.
module scm_gen
  import scm_gen_pkg::*;
#(
  parameter int                        ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                        DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]     CLEAR_VALUE = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   DIN,
  input  logic [DATA_WIDTH/8-1:0] BE,
  input  logic [ADDR_WIDTH-1:0]   WADDR,
  input  logic                    WE,
  input  logic [ADDR_WIDTH-1:0]   RADDR,
  input  logic                    RE,
  output logic [DATA_WIDTH-1:0]   DOUT,
  output logic                    RVALID,
  output logic                    INIT_BUSY
);

  localparam int NUM_ROWS = 2 ** ADDR_WIDTH;
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [NUM_ROWS];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_rvalid;

  logic                  w_init_we;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  w_init_busy;
  logic [DATA_WIDTH-1:0] w_wr_row;
  logic [DATA_WIDTH-1:0] w_rd_row;
  logic [BE_WIDTH-1:0]   w_be;

  scm_gen_init #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init (
    .i_clk       (CLK),
    .i_rst       (RST),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_init_busy (w_init_busy)
  );

  assign w_be     = BE;
  assign w_wr_row = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(r_mem[WADDR]),
                                           MAX_DATA_WIDTH'(DIN),
                                           MAX_BE_WIDTH'(w_be)));

`ifdef SCM_BYPASS_EN
  assign w_rd_row = (WE && (WADDR == RADDR)) ? w_wr_row : r_mem[RADDR];
`else
  assign w_rd_row = r_mem[RADDR];
`endif

  // NOTE: the array has no reset; its contents are cleared by the sweep, which keeps it plain flops.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (w_init_we) begin
        r_mem[w_init_addr] <= CLEAR_VALUE;
      end else if (WE) begin
        r_mem[WADDR] <= w_wr_row;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout   <= '0;
      r_rvalid <= 1'b0;
    end else if (!w_init_busy && RE) begin
      r_dout   <= w_rd_row;
      r_rvalid <= 1'b1;
    end else begin
      r_rvalid <= 1'b0;
    end
  end

  assign DOUT      = r_dout;
  assign RVALID    = r_rvalid;
  assign INIT_BUSY = w_init_busy;

endmodule

// File: tb/tb_scm_gen.sv
// Random and directed bench for scm_gen against a row-array model; build with SCM_BYPASS_EN to test forwarding.
module tb_scm_gen;

  localparam int AW   = 6;
  localparam int DW   = 64;
  localparam int ROWS = 2 ** AW;
`ifdef SCM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic [7:0]    be;
  logic [AW-1:0] waddr;
  logic          we;
  logic [AW-1:0] raddr;
  logic          re;
  logic [DW-1:0] dout;
  logic          rvalid;
  logic          init_busy;

  scm_gen dut (
    .CLK       (clk),
    .RST       (rst),
    .DIN       (din),
    .BE        (be),
    .WADDR     (waddr),
    .WE        (we),
    .RADDR     (raddr),
    .RE        (re),
    .DOUT      (dout),
    .RVALID    (rvalid),
    .INIT_BUSY (init_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: row array plus "edges of sweep remaining".
  logic [DW-1:0] m_mem [ROWS];
  int            m_init_left = ROWS;
  logic [DW-1:0] m_dout = '0;
  logic          m_rvalid = 1'b0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_row,
                                          input logic [DW-1:0] d,
                                          input logic [7:0] mask);
    logic [DW-1:0] bitmask;
    for (int i = 0; i < DW; i++) bitmask[i] = mask[i/8];
    return (old_row & ~bitmask) | (d & bitmask);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply current inputs for one edge, update the model, then compare all outputs.
  task automatic tick(input string tag);
    if (rst) begin
      m_init_left = ROWS;
      m_dout      = '0;
      m_rvalid    = 1'b0;
    end else if (m_init_left > 0) begin
      m_mem[ROWS - m_init_left] = '0;
      m_init_left--;
      m_rvalid = 1'b0;
    end else begin
      if (re) begin
        m_dout   = (BYP && we && waddr == raddr) ? merge(m_mem[raddr], din, be) : m_mem[raddr];
        m_rvalid = 1'b1;
      end else begin
        m_rvalid = 1'b0;
      end
      if (we) m_mem[waddr] = merge(m_mem[waddr], din, be);
    end
    @(posedge clk);
    #1;
    check({tag, "_dout"}, dout, m_dout);
    check({tag, "_rvalid"}, DW'(rvalid), DW'(m_rvalid));
    check({tag, "_busy"}, DW'(init_busy), DW'(m_init_left != 0));
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; be = '0; din = '0; waddr = '0; raddr = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] m);
    idle(); we = 1'b1; waddr = a; din = d; be = m;
    tick("wr");
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    idle(); re = 1'b1; raddr = a;
    tick("rd");
  endtask

  localparam logic [DW-1:0] PAT_A = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [DW-1:0] PAT_B = 64'h5A5A_5A5A_5A5A_5A5A;

  initial begin
    int busy_edges;
    rst = 1'b1;
    idle();

    // Reset held three edges, with requests that must be ignored.
    we = 1'b1; re = 1'b1;
    for (int i = 0; i < 3; i++) tick("reset");
    check("reset_dout_zero", dout, '0);
    rst = 1'b0;
    idle();

    // First sweep: busy must last exactly ROWS edges, requests ignored.
    busy_edges = 0;
    for (int i = 0; i < ROWS + 10 && init_busy === 1'b1; i++) begin
      we = 1'b1; re = 1'b1; din = {$urandom, $urandom}; be = 8'hFF;
      waddr = AW'($urandom); raddr = AW'($urandom);
      tick("init1");
      busy_edges++;
    end
    check("init1_len", DW'(busy_edges), DW'(ROWS));
    idle();

    for (int r = 0; r < ROWS; r++) do_read(AW'(r));

    // Full-row random fill, then randomized traffic with concurrent writes.
    for (int r = 0; r < ROWS; r++) do_write(AW'(r), {$urandom, $urandom}, 8'hFF);
    for (int i = 0; i < 1000; i++) begin
      re    = 1'b1;
      raddr = AW'($urandom);
      we    = ($urandom_range(0, 1) == 1);
      waddr = ($urandom_range(0, 3) == 0) ? raddr : AW'($urandom);
      din   = {$urandom, $urandom};
      be    = 8'($urandom);
      if ($urandom_range(0, 9) == 0) re = 1'b0;
      tick("rand");
    end
    idle();

    // Partial byte write.
    do_write(6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(6'd5, 64'h0011_2233_4455_6677, 8'h0F);
    do_read(6'd5);
    check("be_merge_const", dout, 64'hFFFF_FFFF_4455_6677);
    do_write(6'd5, 64'h0, 8'h00);
    do_read(6'd5);
    check("be_zero_const", dout, 64'hFFFF_FFFF_4455_6677);

    // Same-row same-edge read/write.
    do_write(6'd9, PAT_A, 8'hFF);
    idle(); we = 1'b1; re = 1'b1; waddr = 6'd9; raddr = 6'd9; din = PAT_B; be = 8'hFF;
    tick("collide");
    check("collide_const", dout, BYP ? PAT_B : PAT_A);
    do_read(6'd9);
    check("after_collide_const", dout, PAT_B);

    // Read hold: DOUT stays, RVALID low.
    do_write(6'd3, 64'hC0DE_C0DE_1234_5678, 8'hFF);
    do_read(6'd3);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick("hold");
      check("hold_const", dout, 64'hC0DE_C0DE_1234_5678);
    end

    // Nonzero fill, second sweep interrupted at row 20, restarted sweep clears everything.
    for (int r = 0; r < ROWS; r++) do_write(AW'(r), {$urandom | 32'h1, $urandom}, 8'hFF);
    rst = 1'b1; idle();
    tick("rst2");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick("init2");
    rst = 1'b1;
    tick("rst3");
    rst = 1'b0;
    busy_edges = 0;
    for (int i = 0; i < ROWS + 10 && init_busy === 1'b1; i++) begin
      we = ($urandom_range(0, 1) == 1); re = 1'b1; be = 8'hFF;
      din = {$urandom | 32'h1, $urandom}; waddr = AW'($urandom); raddr = AW'($urandom);
      tick("init3");
      busy_edges++;
    end
    check("init3_len", DW'(busy_edges), DW'(ROWS));
    idle();
    for (int r = 0; r < ROWS; r++) begin
      do_read(AW'(r));
      check("cleared_const", dout, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
